// File: rtl/alu_issue.sv
// alu_issue: single-issue front end that reads a 16x32 register file, drives an external ALU for one cycle,
// and then holds the result until a consumer commits it back to the register file and the flags.
module alu_issue #(
  parameter logic [31:0] RF_RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_opcode,
  input  logic [31:0] alu_out,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [3:0]  result_rd,
  output logic [31:0] result_data,
  output logic        result_err,
  output logic        z_flag,
  output logic        n_flag,
  input  logic [3:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t state, state_nx;
  logic [31:0] rf [16];
  logic [3:0] opcode, rd, rn, rm;
  logic imm_sel, legal, accept, commit;
  assign opcode  = instr[31:28];
  assign rd      = instr[27:24];
  assign rn      = instr[23:20];
  assign rm      = instr[19:16];
  assign imm_sel = instr[15];
  assign legal   = !(opcode == 4'b0101 || opcode >= 4'b1100);
  assign accept  = instr_valid & instr_ready;
  assign commit  = result_valid & result_ready;
  assign dbg_data = rf[dbg_addr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    instr_ready  = state == IDLE;
    result_valid = state == WB;
    state_nx     = (state == IDLE && accept) ? (legal ? EXEC : WB) :
                   (state == EXEC) ? WB :
                   (state == WB && result_ready) ? IDLE : state;
  end
  // ALU operands default to zero every cycle so they are non-zero only during EXEC.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_opcode  <= '0;
      result_rd   <= '0;
      result_data <= '0;
      result_err  <= 1'b0;
      z_flag      <= 1'b0;
      n_flag      <= 1'b0;
      for (int i = 0; i < 16; i++) rf[i] <= RF_RESET_VAL;
    end else begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      if (accept) begin
        result_rd <= rd;
        if (legal) begin
          alu_a      <= rf[rn];
          alu_b      <= imm_sel ? {20'b0, instr[11:0]} : rf[rm];
          alu_opcode <= opcode;
          result_err <= 1'b0;
        end else begin
          result_err  <= 1'b1;
          result_data <= '0;
        end
      end
      if (state == EXEC) result_data <= alu_out;
      if (commit) begin
        result_err <= 1'b0;
        if (!result_err) begin
          rf[result_rd] <= result_data;
          z_flag        <= result_data == '0;
          n_flag        <= result_data[31];
        end
      end
    end
endmodule
